// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the MIPS datapath. Owns the program counter,
// drives the byte address into a 1-cycle registered instruction memory, pairs
// each returned word with its PC and presents it to decode through the IF/ID
// pipeline register. Handles decode stalls and branch/jump redirects from EX.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count and
// stall_count performance counter ports.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  // Fetch-side state: next PC to issue, PC of the word currently on
  // imem_instr, and whether that word is wanted.
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;

  // IF/ID pipeline register.
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        fetch_advance;
  logic        if_id_load;

  // While a wanted word is stalled, re-read its address so the memory keeps
  // presenting the same word; a redirect always issues from pc.
  assign imem_addr = (stall && req_valid_q && !redirect_valid) ? req_pc_q : pc_q;

  // A bubble never blocks the fetch, so refill proceeds even under stall.
  assign fetch_advance = !stall || !req_valid_q;

  // Redirect overrides stall so the flush bubble always enters IF/ID.
  assign if_id_load = !stall || redirect_valid;

  // Next-state for the fetch side: redirect, advance, or hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if (redirect_valid) begin
      pc_d        = {redirect_target[31:2], 2'b00};
      req_pc_d    = imem_addr;
      req_valid_d = 1'b0;
    end else if (fetch_advance) begin
      pc_d        = imem_addr + 32'd4;
      req_pc_d    = imem_addr;
      req_valid_d = 1'b1;
    end
  end

  // Next-state for IF/ID: load the returned word with its PC, or hold.
  always_comb begin
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_valid_d    = if_id_valid_q;
    if (if_id_load) begin
      if_id_instr_d    = imem_instr;
      if_id_pc_d       = req_pc_q;
      if_id_pc_plus4_d = req_pc_q + 32'd4;
      if_id_valid_d    = req_valid_q && !redirect_valid;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0000_0000;
      req_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr_q    <= 32'h0000_0000;
      if_id_pc_q       <= 32'h0000_0000;
      if_id_pc_plus4_q <= 32'h0000_0000;
      if_id_valid_q    <= 1'b0;
    end else begin
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_valid    = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Count real instructions entering IF/ID and cycles spent stalled.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (if_id_load && if_id_valid_d) fetch_count_d = fetch_count_q + 32'd1;
    if (stall)                       stall_count_d = stall_count_q + 32'd1;
  end

  // Performance counter registers; wrap naturally mod 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit. A behavioural instruction
// memory returns word(addr) one edge after the address is presented.
// Optional counter checks compile when FETCH_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int tests_run;
  int tests_failed;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed instruction at 0, an address-derived word elsewhere.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'hAC0A_000A;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Registered-read instruction memory.
  always @(posedge clk) imem_instr <= word(imem_addr);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        chk_pc;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] a, input logic v, input logic c,
                              input logic [31:0] p);
    vec_t x;
    x.stall = s; x.redir = r; x.target = t; x.exp_addr = a;
    x.exp_valid = v; x.chk_pc = c; x.exp_pc = p;
    return x;
  endfunction

  vec_t vecs[19];

  // Apply inputs at a negedge, check the combinational address, take one
  // rising edge, check IF/ID, and return on the following negedge.
  task automatic apply(input vec_t v, input int idx);
    stall           = v.stall;
    redirect_valid  = v.redir;
    redirect_target = v.target;
    #1;
    check($sformatf("vec%0d imem_addr", idx), imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d if_id_valid", idx), {31'b0, if_id_valid}, {31'b0, v.exp_valid});
    if (v.chk_pc) begin
      check($sformatf("vec%0d if_id_pc", idx), if_id_pc, v.exp_pc);
      check($sformatf("vec%0d if_id_pc_plus4", idx), if_id_pc_plus4, v.exp_pc + 32'd4);
      check($sformatf("vec%0d if_id_instr", idx), if_id_instr, word(v.exp_pc));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " if_id_valid"}, {31'b0, if_id_valid}, 32'd0);
    check({tag, " if_id_pc"}, if_id_pc, 32'd0);
    check({tag, " if_id_pc_plus4"}, if_id_pc_plus4, 32'd0);
    check({tag, " if_id_instr"}, if_id_instr, 32'd0);
    check({tag, " imem_addr"}, imem_addr, RESET_PC);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    //          stall redir target        addr          valid chk pc
    vecs[0]  = mk(0, 0, 32'h0,          32'h00,        0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,          32'h04,        1, 1, 32'h00);
    vecs[2]  = mk(0, 0, 32'h0,          32'h08,        1, 1, 32'h04);
    vecs[3]  = mk(1, 0, 32'h0,          32'h08,        1, 1, 32'h04);
    vecs[4]  = mk(1, 0, 32'h0,          32'h08,        1, 1, 32'h04);
    vecs[5]  = mk(1, 0, 32'h0,          32'h08,        1, 1, 32'h04);
    vecs[6]  = mk(0, 0, 32'h0,          32'h0C,        1, 1, 32'h08);
    vecs[7]  = mk(0, 0, 32'h0,          32'h10,        1, 1, 32'h0C);
    vecs[8]  = mk(0, 1, 32'h22,         32'h14,        0, 0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,          32'h20,        0, 0, 32'h0);
    vecs[10] = mk(0, 0, 32'h0,          32'h24,        1, 1, 32'h20);
    vecs[11] = mk(1, 1, 32'h40,         32'h28,        0, 0, 32'h0);
    vecs[12] = mk(1, 0, 32'h0,          32'h40,        0, 0, 32'h0);
    vecs[13] = mk(1, 0, 32'h0,          32'h40,        0, 0, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,          32'h44,        1, 1, 32'h40);
    vecs[15] = mk(0, 0, 32'h0,          32'h48,        1, 1, 32'h44);
    vecs[16] = mk(0, 1, 32'hFFFF_FFFF,  32'h4C,        0, 0, 32'h0);
    vecs[17] = mk(0, 0, 32'h0,          32'hFFFF_FFFC, 0, 0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,          32'h00,        1, 1, 32'hFFFF_FFFC);

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_state("reset");

    // Release reset on a negedge; the next rising edge is edge 1.
    rst_n = 1'b1;
    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset pulse in the middle of a stall.
    stall = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;

    // Startup after reset: word at RESET_PC valid after two edges.
    @(posedge clk);
    #1;
    check("startup edge1 if_id_valid", {31'b0, if_id_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("startup if_id_valid", {31'b0, if_id_valid}, 32'd1);
    check("startup if_id_instr", if_id_instr, 32'hAC0A_000A);
    check("startup if_id_pc", if_id_pc, RESET_PC);
    check("startup if_id_pc_plus4", if_id_pc_plus4, RESET_PC + 32'd4);

`ifdef FETCH_PERF_CNT_EN
    // 11 edges give 10 valid fetches, then 3 stalled edges hold IF/ID.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("perf reset fetch_count", fetch_count, 32'd0);
    check("perf reset stall_count", stall_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    check("perf fetch_count", fetch_count, 32'd10);
    check("perf stall_count", stall_count, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
